// File: rtl/message_encoder.sv
// Encodes a 256-bit message into a 512-coefficient polynomial, one coefficient per cycle,
// either overwriting poly RAM or adding the encoding mod Q to the stored coefficient.
module message_encoder #(
   parameter int Q      = 12289,
   parameter int N      = 512,
   parameter int HALF_Q = 6144
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        add_mode,
   output logic        done,
   output logic [2:0]  msg_addr,
   input  logic [31:0] msg_do,
   output logic [8:0]  poly_addr_rd,
   input  logic [15:0] poly_do,
   output logic        poly_we,
   output logic [8:0]  poly_addr_wr,
   output logic [15:0] poly_di
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [8:0]  r_idx;
   logic [8:0]  w_idx_next;
   logic        r_mode;
   logic        w_mode_next;
   logic        w_issue;
   logic        w_done;

   logic        r_s1_valid;
   logic [8:0]  r_s1_idx;

   logic        w_bit;
   logic [15:0] w_b;
   logic [15:0] w_sum;
   logic [15:0] w_red;
   logic [15:0] w_result;

   logic        r_poly_we;
   logic [8:0]  r_poly_addr_wr;
   logic [15:0] r_poly_di;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_mode  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
         r_mode  <= w_mode_next;
      end
   end

   // In FLUSH, idx doubles as the two-cycle drain counter.
   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_mode_next  = r_mode;
      w_issue      = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_mode_next  = add_mode;
               w_idx_next   = '0;
               w_state_next = RUN;
            end
         end
         RUN: begin
            w_issue    = 1'b1;
            w_idx_next = r_idx + 9'd1;
            if (r_idx == 9'(N - 1)) begin
               w_state_next = FLUSH;
            end
         end
         FLUSH: begin
            w_idx_next = r_idx + 9'd1;
            if (r_idx[0]) begin
               w_idx_next   = '0;
               w_state_next = FIN;
            end
         end
         FIN: begin
            w_done       = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign msg_addr     = r_idx[7:5];
   assign poly_addr_rd = r_idx;
   assign done         = w_done;

   // Stage 1: align idx with the synchronous RAM read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_idx   <= '0;
      end else begin
         r_s1_valid <= w_issue;
         r_s1_idx   <= r_idx;
      end
   end

   // Inputs are at most 12288 + 6144, so one conditional subtraction reduces them.
   always_comb begin
      w_bit    = msg_do[r_s1_idx[4:0]];
      w_b      = w_bit ? 16'(HALF_Q) : 16'd0;
      w_sum    = poly_do + w_b;
      w_red    = (w_sum >= 16'(Q)) ? (w_sum - 16'(Q)) : w_sum;
      w_result = r_mode ? w_red : w_b;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_poly_we      <= 1'b0;
         r_poly_addr_wr <= '0;
         r_poly_di      <= '0;
      end else begin
         r_poly_we <= r_s1_valid;
         if (r_s1_valid) begin
            r_poly_addr_wr <= r_s1_idx;
            r_poly_di      <= w_result;
         end
      end
   end

   assign poly_we      = r_poly_we;
   assign poly_addr_wr = r_poly_addr_wr;
   assign poly_di      = r_poly_di;

endmodule

// File: tb/tb_message_encoder.sv
// Self-checking bench for message_encoder: RAM models, pass timing capture and a
// coefficient reference model derived from the encoding rules.
module tb_message_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        add_mode;
   logic        done;
   logic [2:0]  msg_addr;
   logic [31:0] msg_do;
   logic [8:0]  poly_addr_rd;
   logic [15:0] poly_do;
   logic        poly_we;
   logic [8:0]  poly_addr_wr;
   logic [15:0] poly_di;

   always #5 clk = ~clk;

   message_encoder dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .add_mode     (add_mode),
      .done         (done),
      .msg_addr     (msg_addr),
      .msg_do       (msg_do),
      .poly_addr_rd (poly_addr_rd),
      .poly_do      (poly_do),
      .poly_we      (poly_we),
      .poly_addr_wr (poly_addr_wr),
      .poly_di      (poly_di)
   );

   logic [31:0] msg_mem [8];
   logic [15:0] poly_mem [512];
   logic [15:0] preload [512];
   logic        load_req = 1'b0;

   always @(posedge clk) begin
      msg_do  <= msg_mem[msg_addr];
      poly_do <= poly_mem[poly_addr_rd];
      if (load_req) begin
         for (int k = 0; k < 512; k++) poly_mem[k] <= preload[k];
      end else if (poly_we) begin
         poly_mem[poly_addr_wr] <= poly_di;
      end
   end

   int checks = 0;
   int errors = 0;
   int orig [512];
   int done_cyc, done_cnt, we_cnt, first_we, last_we, rd_bad, msg_bad;
   int wr_q[$];

   function automatic int ref_coef(int k, int o, bit m);
      int b;
      int t;
      b = msg_mem[(k % 256) / 32][k % 32] ? 6144 : 0;
      if (!m) return b;
      t = (o + b) % 65536;
      if (t >= 12289) t = t - 12289;
      return t;
   endfunction

   task automatic load_poly();
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
      for (int k = 0; k < 512; k++) orig[k] = int'(preload[k]);
   endtask

   // Cycle k of the loop is cycle s+k, where s is the cycle start is sampled.
   task automatic run_pass(input bit mode, input int rst_at, input int st_a, input int st_b);
      add_mode = mode;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      add_mode = ~mode;
      done_cyc = -1; done_cnt = 0; we_cnt = 0; first_we = -1; last_we = -1;
      rd_bad = 0; msg_bad = 0;
      wr_q.delete();
      for (int k = 1; k <= 520; k++) begin
         if (k == rst_at) rst = 1'b1;
         if (k == st_a || k == st_b) start = 1'b1;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (poly_we) begin
            we_cnt++;
            if (first_we < 0) first_we = k;
            last_we = k;
            wr_q.push_back(int'(poly_addr_wr));
         end
         if (k <= 512 && rst_at < 0) begin
            if (poly_addr_rd !== 9'(k - 1)) rd_bad++;
            if (msg_addr !== 3'(((k - 1) % 256) / 32)) msg_bad++;
         end
         @(posedge clk); #1;
         rst   = 1'b0;
         start = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; add_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({done, poly_we} !== 2'b00) begin
         errors++; $display("FAIL reset_strobes: got done=%0b we=%0b expected 0 0", done, poly_we);
      end
      checks++;
      if (msg_addr !== 3'd0 || poly_addr_rd !== 9'd0) begin
         errors++; $display("FAIL reset_rd_addr: got msg=%0d rd=%0d expected 0 0", msg_addr, poly_addr_rd);
      end
      checks++;
      if (poly_addr_wr !== 9'd0 || poly_di !== 16'd0) begin
         errors++; $display("FAIL reset_wr: got addr=%0d di=%0d expected 0 0", poly_addr_wr, poly_di);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      $display("reset: checked outputs after reset");
   endtask

   task automatic test_overwrite_zero();
      for (int w = 0; w < 8; w++) msg_mem[w] = 32'h0;
      for (int k = 0; k < 512; k++) preload[k] = 16'($urandom_range(12288, 0));
      load_poly();
      run_pass(1'b0, -1, -1, -1);
      checks++;
      if (done_cyc != 515 || done_cnt != 1) begin
         errors++; $display("FAIL zero_done: got cycle=%0d count=%0d expected 515 1", done_cyc, done_cnt);
      end
      checks++;
      if (we_cnt != 512 || first_we != 3 || last_we != 514) begin
         errors++; $display("FAIL zero_we: got cnt=%0d first=%0d last=%0d expected 512 3 514", we_cnt, first_we, last_we);
      end
      checks++;
      if (rd_bad != 0 || msg_bad != 0) begin
         errors++; $display("FAIL zero_rd_addr: got bad rd=%0d msg=%0d expected 0 0", rd_bad, msg_bad);
      end
      for (int k = 0; k < 512; k++) begin
         checks++;
         if (poly_mem[k] !== 16'd0) begin
            errors++; $display("FAIL zero_coef[%0d]: got %0d expected 0", k, poly_mem[k]);
         end
      end
      $display("overwrite_zero: done at s+%0d, %0d writes", done_cyc, we_cnt);
   endtask

   task automatic test_overwrite_word0();
      int seq_bad;
      for (int w = 0; w < 8; w++) msg_mem[w] = 32'h0;
      msg_mem[0] = 32'h0000_0001;
      for (int k = 0; k < 512; k++) preload[k] = 16'($urandom_range(12288, 0));
      load_poly();
      run_pass(1'b0, -1, -1, -1);
      seq_bad = 0;
      for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] != i) seq_bad++;
      checks++;
      if (seq_bad != 0 || wr_q.size() != 512) begin
         errors++; $display("FAIL word0_wr_seq: got %0d out of order of %0d expected 0 of 512", seq_bad, wr_q.size());
      end
      for (int k = 0; k < 512; k++) begin
         checks++;
         if (int'(poly_mem[k]) != ((k == 0 || k == 256) ? 6144 : 0)) begin
            errors++; $display("FAIL word0_coef[%0d]: got %0d expected %0d", k, poly_mem[k], (k == 0 || k == 256) ? 6144 : 0);
         end
      end
      $display("overwrite_word0: coef0=%0d coef256=%0d", poly_mem[0], poly_mem[256]);
   endtask

   task automatic test_add_ramp();
      for (int w = 0; w < 8; w++) msg_mem[w] = 32'hFFFF_FFFF;
      for (int k = 0; k < 512; k++) preload[k] = 16'(k);
      preload[10] = 16'd6144;
      preload[11] = 16'd6145;
      load_poly();
      run_pass(1'b1, -1, -1, -1);
      checks++;
      if (poly_mem[10] !== 16'd12288) begin
         errors++; $display("FAIL ramp_6144: got %0d expected 12288", poly_mem[10]);
      end
      checks++;
      if (poly_mem[11] !== 16'd0) begin
         errors++; $display("FAIL ramp_6145: got %0d expected 0", poly_mem[11]);
      end
      checks++;
      if (poly_mem[511] !== 16'd6655) begin
         errors++; $display("FAIL ramp_511: got %0d expected 6655", poly_mem[511]);
      end
      for (int k = 0; k < 512; k++) begin
         checks++;
         if (int'(poly_mem[k]) != ref_coef(k, orig[k], 1'b1)) begin
            errors++; $display("FAIL ramp_coef[%0d]: got %0d expected %0d", k, poly_mem[k], ref_coef(k, orig[k], 1'b1));
         end
      end
      $display("add_ramp: coef10=%0d coef11=%0d coef511=%0d", poly_mem[10], poly_mem[11], poly_mem[511]);
   endtask

   task automatic test_add_edges();
      for (int w = 0; w < 8; w++) msg_mem[w] = $urandom;
      msg_mem[0] = (msg_mem[0] & 32'hFFFF_FFE0) | 32'h0000_0005;
      for (int k = 0; k < 512; k++) preload[k] = 16'($urandom_range(12288, 0));
      preload[0] = 16'd12288;
      preload[1] = 16'd12288;
      preload[2] = 16'd0;
      preload[4] = 16'd20000;
      load_poly();
      run_pass(1'b1, -1, -1, -1);
      checks++;
      if (poly_mem[0] !== 16'd6143) begin
         errors++; $display("FAIL edge_max_bit1: got %0d expected 6143", poly_mem[0]);
      end
      checks++;
      if (poly_mem[1] !== 16'd12288) begin
         errors++; $display("FAIL edge_max_bit0: got %0d expected 12288", poly_mem[1]);
      end
      checks++;
      if (poly_mem[2] !== 16'd6144) begin
         errors++; $display("FAIL edge_zero_bit1: got %0d expected 6144", poly_mem[2]);
      end
      checks++;
      if (poly_mem[4] !== 16'd7711) begin
         errors++; $display("FAIL edge_oversize: got %0d expected 7711", poly_mem[4]);
      end
      for (int k = 5; k < 512; k++) begin
         checks++;
         if (int'(poly_mem[k]) != ref_coef(k, orig[k], 1'b1)) begin
            errors++; $display("FAIL edge_coef[%0d]: got %0d expected %0d", k, poly_mem[k], ref_coef(k, orig[k], 1'b1));
         end
      end
      $display("add_edges: %0d %0d %0d %0d", poly_mem[0], poly_mem[1], poly_mem[2], poly_mem[4]);
   endtask

   task automatic test_word7();
      int exp_v;
      for (int w = 0; w < 8; w++) msg_mem[w] = 32'h0;
      msg_mem[7] = 32'h8000_0000;
      for (int k = 0; k < 512; k++) preload[k] = 16'($urandom_range(12288, 0));
      load_poly();
      run_pass(1'b1, -1, -1, -1);
      checks++;
      if (msg_bad != 0) begin
         errors++; $display("FAIL word7_msg_addr: got %0d bad cycles expected 0", msg_bad);
      end
      for (int k = 0; k < 512; k++) begin
         exp_v = orig[k];
         if (k == 255 || k == 511) exp_v = (orig[k] + 6144 >= 12289) ? orig[k] + 6144 - 12289 : orig[k] + 6144;
         checks++;
         if (int'(poly_mem[k]) != exp_v) begin
            errors++; $display("FAIL word7_coef[%0d]: got %0d expected %0d", k, poly_mem[k], exp_v);
         end
      end
      $display("word7: coef255=%0d coef511=%0d", poly_mem[255], poly_mem[511]);
   endtask

   task automatic test_rst_mid();
      for (int w = 0; w < 8; w++) msg_mem[w] = $urandom;
      for (int k = 0; k < 512; k++) preload[k] = 16'($urandom_range(12288, 0));
      load_poly();
      run_pass(1'b1, 200, -1, -1);
      checks++;
      if (done_cnt != 0) begin
         errors++; $display("FAIL rst_done: got %0d pulses expected 0", done_cnt);
      end
      checks++;
      if (last_we > 200 || we_cnt > 198) begin
         errors++; $display("FAIL rst_we: got last=%0d cnt=%0d expected last<=200 cnt<=198", last_we, we_cnt);
      end
      for (int k = 0; k < 512; k++) begin
         if (k >= 199 || k <= 197) begin
            checks++;
            if (int'(poly_mem[k]) != ((k >= 199) ? orig[k] : ref_coef(k, orig[k], 1'b1))) begin
               errors++; $display("FAIL rst_coef[%0d]: got %0d expected %0d", k, poly_mem[k],
                                  (k >= 199) ? orig[k] : ref_coef(k, orig[k], 1'b1));
            end
         end
      end
      $display("rst_mid: %0d writes before reset", we_cnt);
   endtask

   task automatic test_back_to_back(input int st_a, input int st_b);
      bit m;
      m = 1'($urandom);
      for (int w = 0; w < 8; w++) msg_mem[w] = $urandom;
      for (int k = 0; k < 512; k++) preload[k] = 16'($urandom_range(12288, 0));
      load_poly();
      run_pass(m, -1, st_a, st_b);
      checks++;
      if (done_cyc != 515 || done_cnt != 1) begin
         errors++; $display("FAIL b2b_done: got cycle=%0d count=%0d expected 515 1", done_cyc, done_cnt);
      end
      checks++;
      if (we_cnt != 512 || first_we != 3 || last_we != 514) begin
         errors++; $display("FAIL b2b_we: got cnt=%0d first=%0d last=%0d expected 512 3 514", we_cnt, first_we, last_we);
      end
      for (int k = 0; k < 512; k++) begin
         checks++;
         if (int'(poly_mem[k]) != ref_coef(k, orig[k], m)) begin
            errors++; $display("FAIL b2b_coef[%0d]: got %0d expected %0d", k, poly_mem[k], ref_coef(k, orig[k], m));
         end
      end
      $display("back_to_back: mode=%0b extra starts at %0d,%0d done at s+%0d", m, st_a, st_b, done_cyc);
   endtask

   initial begin
      test_reset();
      test_overwrite_zero();
      test_overwrite_word0();
      test_add_ramp();
      test_add_edges();
      test_word7();
      test_rst_mid();
      test_back_to_back(100, 515);
      test_back_to_back(5, 300);
      test_back_to_back(-1, -1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
